stream_burst_source: RTL and testbench

Valid/ready stream producer: the transmitting end for our registered pipeline stages and downstream consumers. On a start command it emits a burst of START_LEN beats. Beat data starts at a seed and increments by 1 per beat. Optional idle gap cycles separate beats. It obeys downstream backpressure strictly: data and last stay stable while stalled. It is the bring-up and throughput traffic generator placed ahead of pipeline chains.

---
 rtl/stream_burst_source_if.sv | 28 ++
 rtl/stream_burst_source.sv | 162 ++++++++++++++++
 tb/tb_stream_burst_source.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_burst_source_if.sv
// Valid/ready beat stream between a producer and a consumer.
//   out_valid : producer has a beat on out_data/out_last
//   out_ready : consumer can take the beat this cycle
//   out_data  : beat payload
//   out_last  : marks the final beat of a burst
// master: the producing side. slave: the consuming side.
interface stream_burst_source_if #(
  parameter int WIDTH = 32
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/stream_burst_source.sv
// Burst traffic generator with a valid/ready output stream.
// On an accepted start it emits start_len beats whose data counts up from
// start_seed (wrapping modulo 2^WIDTH), with start_gap idle cycles after
// each accepted non-final beat. Beats are held stable under backpressure.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : command strobe, only looked at while idle
//   start_seed  : data of the first beat
//   start_len   : beats in the burst (0 = pulse done, send nothing)
//   start_gap   : idle cycles after each accepted non-final beat
//   busy        : a burst is in progress
//   done        : one-cycle pulse when a burst ends (or zero-length start)
//   stall_cnt   : cycles this burst spent valid but not accepted, saturating
//   m           : output stream (master side)
// Every output comes straight from a flop; out_ready only steers next state.
module stream_burst_source #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int GAP_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      start_seed,
  input  logic [LEN_W-1:0]      start_len,
  input  logic [GAP_W-1:0]      start_gap,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           stall_cnt,
  stream_burst_source_if.master m
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, nxt_state;
  logic [LEN_W-1:0] remain, nxt_remain;      // beats left, including the one on the bus
  logic [GAP_W-1:0] gap_lat, nxt_gap_lat;    // gap length latched at start
  logic [GAP_W-1:0] gap_cnt, nxt_gap_cnt;    // idle cycles still to spend in GAP
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_valid, nxt_last, nxt_done, nxt_busy;
  logic [31:0]      nxt_stall;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  always_comb begin
    nxt_state   = state;
    nxt_remain  = remain;
    nxt_gap_lat = gap_lat;
    nxt_gap_cnt = gap_cnt;
    nxt_data    = m.out_data;
    nxt_valid   = m.out_valid;
    nxt_last    = m.out_last;
    nxt_done    = 1'b0;
    nxt_stall   = stall_cnt;

    case (state)
      IDLE: begin
        nxt_valid = 1'b0;
        nxt_last  = 1'b0;
        if (start) begin
          nxt_stall = 32'd0;
          if (start_len == '0) begin
            nxt_done = 1'b1;
          end else begin
            nxt_state   = SEND;
            nxt_remain  = start_len;
            nxt_gap_lat = start_gap;
            nxt_data    = start_seed;
            nxt_valid   = 1'b1;
            nxt_last    = (start_len == LEN_W'(1));
          end
        end
      end

      SEND: begin
        if (m.out_ready) begin
          if (remain == LEN_W'(1)) begin
            // Final beat accepted; out_data keeps its value.
            nxt_state  = IDLE;
            nxt_remain = '0;
            nxt_valid  = 1'b0;
            nxt_last   = 1'b0;
            nxt_done   = 1'b1;
          end else begin
            nxt_remain = remain - LEN_W'(1);
            nxt_data   = wrap_inc(m.out_data);
            if (gap_lat == '0) begin
              nxt_valid = 1'b1;
              nxt_last  = (remain == LEN_W'(2));
            end else begin
              // Data advances now; last is raised again when valid returns.
              nxt_state   = GAP;
              nxt_valid   = 1'b0;
              nxt_last    = 1'b0;
              nxt_gap_cnt = gap_lat;
            end
          end
        end else begin
          nxt_stall = sat_inc32(stall_cnt);
        end
      end

      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          nxt_state   = SEND;
          nxt_gap_cnt = '0;
          nxt_valid   = 1'b1;
          nxt_last    = (remain == LEN_W'(1));
        end else begin
          nxt_gap_cnt = gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        nxt_state = IDLE;
        nxt_valid = 1'b0;
        nxt_last  = 1'b0;
      end
    endcase

    nxt_busy = (nxt_state != IDLE);
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remain      <= '0;
      gap_lat     <= '0;
      gap_cnt     <= '0;
      m.out_data  <= '0;
      m.out_valid <= 1'b0;
      m.out_last  <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      stall_cnt   <= 32'd0;
    end else begin
      state       <= nxt_state;
      remain      <= nxt_remain;
      gap_lat     <= nxt_gap_lat;
      gap_cnt     <= nxt_gap_cnt;
      m.out_data  <= nxt_data;
      m.out_valid <= nxt_valid;
      m.out_last  <= nxt_last;
      done        <= nxt_done;
      busy        <= nxt_busy;
      stall_cnt   <= nxt_stall;
    end
  end

endmodule

// File: tb/tb_stream_burst_source.sv
// Self-checking bench for stream_burst_source: a table of directed bursts,
// hand-written corner sequences, and randomized bursts, all watched every
// cycle by a transaction-level reference model (queue of expected beats).
module tb_stream_burst_source;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] start_seed;
  logic [15:0] start_len;
  logic [3:0]  start_gap;
  logic        busy;
  logic        done;
  logic [31:0] stall_cnt;

  stream_burst_source_if #(.WIDTH(32)) bus ();

  stream_burst_source #(.WIDTH(32), .LEN_W(16), .GAP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_seed (start_seed),
    .start_len  (start_len),
    .start_gap  (start_gap),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt),
    .m          (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] seed;
    logic [15:0] len;
    logic [3:0]  gap;
    logic [15:0] low_mask;      // bit k: out_ready low k cycles after start
    logic [31:0] exp_last_data;
    logic [31:0] exp_stall;
    int          exp_done_k;    // cycles from start to done pulse
  } vec_t;

  // Reference model state
  beat_t       q[$];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_stall = 32'd0;
  logic [3:0]  m_gap = 4'd0;
  int          m_wait = 0;

  // Snapshot of DUT outputs taken mid-cycle
  logic        s_valid, s_ready, s_last, s_done, s_busy;
  logic [31:0] s_data, s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  task automatic model_step();
    logic  exp_valid;
    beat_t b;
    if (!rst_n) begin
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_done", 32'(s_done), 32'd0);
      chk("rst_last", 32'(s_last), 32'd0);
      chk("rst_data", s_data, 32'd0);
      chk("rst_stall", s_stall, 32'd0);
      q.delete();
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_stall = 32'd0;
      m_wait  = 0;
    end else begin
      exp_valid = m_busy && (m_wait == 0);
      chk("valid", 32'(s_valid), 32'(exp_valid));
      if (exp_valid) begin
        if (q.size() == 0) begin
          fail_now("beat_queue_empty");
        end else begin
          chk("data", s_data, q[0].data);
          chk("last", 32'(s_last), 32'(q[0].last));
        end
      end
      chk("done", 32'(s_done), 32'(m_done));
      chk("busy", 32'(s_busy), 32'(m_busy));
      chk("stall_cnt", s_stall, m_stall);

      m_done = 1'b0;
      if (exp_valid && !s_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (!m_busy) begin
        if (start) begin
          m_stall = 32'd0;
          if (start_len == 16'd0) begin
            m_done = 1'b1;
          end else begin
            for (int i = 0; i < int'(start_len); i++) begin
              b.data = start_seed + 32'(i);
              b.last = (i == int'(start_len) - 1);
              q.push_back(b);
            end
            m_busy = 1'b1;
            m_wait = 0;
            m_gap  = start_gap;
          end
        end
      end else if (exp_valid && s_ready) begin
        if (q.size() > 0) begin
          b = q.pop_front();
          if (b.last) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_wait = int'(m_gap);
          end
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end
    end
  endtask

  // One clock: snapshot and model at the falling edge, return just after
  // the rising edge so the caller can drive the next cycle's inputs.
  task automatic tick();
    @(negedge clk);
    s_valid = bus.out_valid;
    s_ready = bus.out_ready;
    s_last  = bus.out_last;
    s_data  = bus.out_data;
    s_done  = done;
    s_busy  = busy;
    s_stall = stall_cnt;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int          got_done;
    logic [31:0] last_hs;
    logic [31:0] done_stall;
    start      = 1'b1;
    start_seed = v.seed;
    start_len  = v.len;
    start_gap  = v.gap;
    bus.out_ready = !v.low_mask[0];
    tick();
    start    = 1'b0;
    got_done = -1;
    last_hs  = 32'hDEAD_BEEF;
    done_stall = 32'd0;
    for (int k = 1; k < 200 && got_done < 0; k++) begin
      bus.out_ready = (k < 16) ? !v.low_mask[k] : 1'b1;
      start_seed = $urandom;
      start_len  = 16'($urandom);
      tick();
      if (k == 1) begin
        chk($sformatf("v%0d_first_valid", idx), 32'(s_valid), 32'(v.len != 16'd0));
        if (v.len != 16'd0) chk($sformatf("v%0d_first_data", idx), s_data, v.seed);
      end
      if (s_valid && s_ready) last_hs = s_data;
      if (s_done) begin
        got_done   = k;
        done_stall = s_stall;
      end
    end
    if (got_done < 0) begin
      fail_now($sformatf("v%0d_done_timeout", idx));
    end else begin
      chk($sformatf("v%0d_done_cycle", idx), 32'(got_done), 32'(v.exp_done_k));
      chk($sformatf("v%0d_stall", idx), done_stall, v.exp_stall);
      if (v.len != 16'd0) chk($sformatf("v%0d_last_data", idx), last_hs, v.exp_last_data);
    end
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  // Runs until the model reports idle, throwing random backpressure and
  // start strobes (which must be ignored) at the DUT meanwhile.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (m_busy && n < 500) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      start      = m_busy && ($urandom_range(0, 7) == 0);
      start_seed = $urandom;
      start_len  = 16'($urandom_range(0, 5));
      start_gap  = 4'($urandom_range(0, 3));
      tick();
      n++;
    end
    start = 1'b0;
    if (m_busy) fail_now(name);
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0000_0010, 16'd4, 4'd0, 16'h0000, 32'h0000_0013, 32'd0, 5};
    vecs[1] = '{32'h0000_00A0, 16'd3, 4'd0, 16'h001C, 32'h0000_00A2, 32'd3, 7};
    vecs[2] = '{32'h0000_0000, 16'd3, 4'd2, 16'h0000, 32'h0000_0002, 32'd0, 8};
    vecs[3] = '{32'hFFFF_FFFE, 16'd3, 4'd0, 16'h0000, 32'h0000_0000, 32'd0, 4};
    vecs[4] = '{32'h0000_1234, 16'd1, 4'd5, 16'h0000, 32'h0000_1234, 32'd0, 2};
    vecs[5] = '{32'h0000_0007, 16'd2, 4'd1, 16'h0002, 32'h0000_0008, 32'd1, 5};
    vecs[6] = '{32'h0000_0009, 16'd0, 4'd0, 16'h0000, 32'h0000_0000, 32'd0, 1};

    rst_n = 1'b0;
    start = 1'b0;
    start_seed = 32'd0;
    start_len  = 16'd0;
    start_gap  = 4'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

    // Start while busy is ignored; start on the done cycle is accepted.
    start = 1'b1; start_seed = 32'h100; start_len = 16'd6; start_gap = 4'd0;
    bus.out_ready = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        start = 1'b1; start_seed = 32'h55; start_len = 16'd2; start_gap = 4'd3;
      end else if (k == 7) begin
        start = 1'b1; start_seed = 32'h200; start_len = 16'd2; start_gap = 4'd0;
      end else begin
        start = 1'b0;
      end
      tick();
      if (k == 3) chk("ign_data", s_data, 32'h102);
      if (k == 6) begin
        chk("ign_last_data", s_data, 32'h105);
        chk("ign_last_flag", 32'(s_last), 32'd1);
      end
      if (k == 7) chk("b2b_done", 32'(s_done), 32'd1);
      if (k == 8) begin
        chk("b2b_valid", 32'(s_valid), 32'd1);
        chk("b2b_data", s_data, 32'h200);
      end
    end
    start = 1'b0;
    wait_idle("b2b_timeout");

    // Reset in the middle of a burst.
    start = 1'b1; start_seed = 32'h40; start_len = 16'd8; start_gap = 4'd0;
    bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("rst_mid_beat3", s_data, 32'h42);
    rst_n = 1'b0;
    #1;
    chk("rst_imm_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm_busy", 32'(busy), 32'd0);
    chk("rst_imm_stall", stall_cnt, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_done", 32'(s_done), 32'd0);
    end
    apply_vec(vecs[0], 10);

    // Randomized bursts checked by the model.
    for (int n = 0; n < 40; n++) begin
      start      = 1'b1;
      start_seed = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 4))) : $urandom;
      start_len  = 16'($urandom_range(0, 12));
      start_gap  = 4'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick();
      start = 1'b0;
      wait_idle("rand_timeout");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
